// File: rtl/key_event_fsm.sv
// key_event_fsm: classifies a debounced key level into short-press, long-press
// and double-click events, each a single-cycle registered pulse.
// Ports:
//   sys_clk      - system clock, rising edge
//   rst          - synchronous active-high reset
//   key_i        - debounced key level
//   short_press  - pulse: single click completed (gap timed out)
//   long_press   - pulse: key held LONG_TIME cycles
//   double_click - pulse: second click released
//   busy         - high whenever the FSM is not idle
//   state_o      - current state encoding (debug)
module key_event_fsm #(
    parameter int unsigned LONG_TIME  = 50_000_000,
    parameter int unsigned DCLICK_GAP = 15_000_000,
    parameter int unsigned CNT_BITS   = 26,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       key_i,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic       busy,
    output logic [2:0] state_o
);

    localparam logic [CNT_BITS-1:0] LONG_LAST = CNT_BITS'(LONG_TIME - 1);
    localparam logic [CNT_BITS-1:0] GAP_LAST  = CNT_BITS'(DCLICK_GAP - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CNT_BITS-1:0] cnt;
    logic                prev;
    logic                pressed;
    logic                press_edge;
    logic                release_edge;
    logic                fire_short;
    logic                fire_long;
    logic                fire_dbl;

    // Normalise polarity and detect edges against the previous sample
    assign pressed      = key_i ^ ACTIVE_LOW;
    assign press_edge   = pressed & ~prev;
    assign release_edge = ~pressed & prev;
    assign state_o      = state;

    // Next-state and pulse decode; edges take priority over timeouts
    always_comb begin
        next_state = state;
        fire_short = 1'b0;
        fire_long  = 1'b0;
        fire_dbl   = 1'b0;
        case (state)
            IDLE: begin
                if (press_edge) next_state = PRESS1;
            end
            PRESS1: begin
                if (release_edge) begin
                    next_state = WAIT2;
                end else if (cnt == LONG_LAST) begin
                    next_state = LONG_HOLD;
                    fire_long  = 1'b1;
                end
            end
            WAIT2: begin
                if (press_edge) begin
                    next_state = PRESS2;
                end else if (cnt == GAP_LAST) begin
                    next_state = IDLE;
                    fire_short = 1'b1;
                end
            end
            PRESS2: begin
                if (release_edge) begin
                    next_state = IDLE;
                    fire_dbl   = 1'b1;
                end
            end
            LONG_HOLD: begin
                if (release_edge) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            prev         <= pressed;  // key held through reset yields no edge
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= next_state;
            prev         <= pressed;
            short_press  <= fire_short;
            long_press   <= fire_long;
            double_click <= fire_dbl;
            busy         <= (next_state != IDLE);
            // Counter only runs while timing a hold or a gap
            if (next_state != state) begin
                cnt <= '0;
            end else if (state == PRESS1 || state == WAIT2) begin
                cnt <= cnt + CNT_BITS'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule
